div_seq_unit: RTL and testbench

Sequential signed 32-bit divider feeding the HI/LO registers of the multicycle datapath. It accepts a dividend/divisor pair on a one-cycle start pulse and runs a radix-2 restoring iteration on magnitudes. It returns quotient on `lo` and remainder on `hi` with MIPS `div` semantics, plus a divide-by-zero flag the control unit turns into an exception.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_seq_unit_if.sv | 27 ++
 rtl/abs_negate.sv | 12 +
 rtl/div_seq_unit.sv | 133 +++++++++++++
 tb/tb_div_seq_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        ZERO
    } div_state_t;

endpackage

// File: rtl/div_seq_unit_if.sv
// Request/response bundle between the control unit and the divider.
interface div_seq_unit_if
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, a, b,
        output busy, done, div_zero, hi, lo
    );

endinterface

// File: rtl/abs_negate.sv
// Two's-complement conditional negate; with negate tied to the MSB it yields the magnitude.
module abs_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + 1'b1) : value;

endmodule

// File: rtl/div_seq_unit.sv
// Radix-2 restoring signed divider: quotient on lo, remainder on hi, MIPS div semantics.
module div_seq_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input logic          clock,
    input logic          reset,
    div_seq_unit_if.slave bus
);

    localparam int unsigned RemW = WIDTH + 1;

    div_state_t           state_q;
    logic [WIDTH:0]       rem_q;
    logic [WIDTH-1:0]     quo_q;
    logic [WIDTH-1:0]     dvs_q;
    logic [DIV_CNT_W-1:0] count_q;
    logic                 sign_q;
    logic                 sign_r;
    logic                 busy_q;
    logic                 done_q;
    logic                 div_zero_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] lo_fixed;
    logic [WIDTH-1:0] hi_fixed;

    abs_negate #(.WIDTH(WIDTH)) u_abs_a (
        .value  (bus.a),
        .negate (bus.a[WIDTH-1]),
        .result (a_mag)
    );

    abs_negate #(.WIDTH(WIDTH)) u_abs_b (
        .value  (bus.b),
        .negate (bus.b[WIDTH-1]),
        .result (b_mag)
    );

    abs_negate #(.WIDTH(WIDTH)) u_fix_lo (
        .value  (quo_q),
        .negate (sign_q),
        .result (lo_fixed)
    );

    // A finished remainder is below |b| <= 2^(WIDTH-1), so the low WIDTH bits hold it.
    abs_negate #(.WIDTH(WIDTH)) u_fix_hi (
        .value  (rem_q[WIDTH-1:0]),
        .negate (sign_r),
        .result (hi_fixed)
    );

    logic [WIDTH+1:0] rem_shift;
    logic [WIDTH+1:0] rem_sub;
    logic             take;

    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        rem_sub   = rem_shift - {2'b00, dvs_q};
        take      = rem_shift >= {2'b00, dvs_q};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            count_q    <= '0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.b == '0) begin
                            state_q <= ZERO;
                        end else begin
                            state_q <= CALC;
                            quo_q   <= a_mag;
                            dvs_q   <= b_mag;
                            rem_q   <= '0;
                            count_q <= DIV_CNT_W'(WIDTH - 1);
                            sign_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                            sign_r  <= bus.a[WIDTH-1];
                        end
                    end
                end
                CALC: begin
                    rem_q   <= RemW'(take ? rem_sub : rem_shift);
                    quo_q   <= {quo_q[WIDTH-2:0], take};
                    count_q <= count_q - 1'b1;
                    if (count_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    lo_q       <= lo_fixed;
                    hi_q       <= hi_fixed;
                    done_q     <= 1'b1;
                    div_zero_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                ZERO: begin
                    done_q     <= 1'b1;
                    div_zero_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// Self-checking bench for div_seq_unit: directed scenarios plus randomized ops vs. an arithmetic model.
module tb_div_seq_unit;
    import div_pkg::*;

    localparam int unsigned W = DIV_WIDTH;

    logic clock = 1'b0;
    logic reset = 1'b0;

    div_seq_unit_if bus ();

    div_seq_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;
    logic         exp_dz = 1'b0;

    // Reference: plain signed arithmetic; zero divisor keeps hi/lo, overflow case wraps.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == '0) begin
            exp_dz = 1'b1;
        end else begin
            exp_dz = 1'b0;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                exp_lo = 32'h8000_0000;
                exp_hi = '0;
            end else begin
                exp_lo = sa / sb;
                exp_hi = sa % sb;
            end
        end
    endfunction

    // Called mid-cycle; returns 1 ns after the accepting edge with operands scrambled.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        model(a, b);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = -1;
        busy_cyc = bus.busy ? 1 : 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock);
            #1;
            if (bus.done) begin
                lat = c;
                break;
            end
            if (bus.busy) busy_cyc++;
        end
        if (lat < 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: no done within 40 cycles, required done");
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", bus.done); end
        tests++; if (bus.div_zero !== 1'b0) begin fails++; $display("FAIL reset_dz got %b exp 0", bus.div_zero); end
        tests++; if (bus.hi !== '0) begin fails++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
        tests++; if (bus.lo !== '0) begin fails++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic();
        int lat, bc;
        launch(32'd7, 32'd2);
        wait_done(lat, bc);
        tests++; if (bus.lo !== 32'd3) begin fails++; $display("FAIL basic_lo got %h exp 3", bus.lo); end
        tests++; if (bus.hi !== 32'd1) begin fails++; $display("FAIL basic_hi got %h exp 1", bus.hi); end
        tests++; if (bus.div_zero !== 1'b0) begin fails++; $display("FAIL basic_dz got %b exp 0", bus.div_zero); end
        tests++; if (lat != 33) begin fails++; $display("FAIL basic_latency got %0d exp 33", lat); end
        tests++; if (bc != 33) begin fails++; $display("FAIL basic_busy_cycles got %0d exp 33", bc); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done got %b exp 0", bus.busy); end
        @(posedge clock);
        #1;
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL basic_done_width got %b exp 0", bus.done); end
    endtask

    task automatic test_signs();
        logic [W-1:0] ta [4] = '{32'hFFFF_FFF9, 32'd7,         32'h8000_0000, 32'd5};
        logic [W-1:0] tb [4] = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd9};
        logic [W-1:0] tl [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'd0};
        logic [W-1:0] th [4] = '{32'hFFFF_FFFF, 32'd1,         32'd0,         32'd5};
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            launch(ta[i], tb[i]);
            wait_done(lat, bc);
            tests++; if (bus.lo !== tl[i]) begin fails++; $display("FAIL signs_lo[%0d] got %h exp %h", i, bus.lo, tl[i]); end
            tests++; if (bus.hi !== th[i]) begin fails++; $display("FAIL signs_hi[%0d] got %h exp %h", i, bus.hi, th[i]); end
            tests++; if (bus.div_zero !== 1'b0) begin fails++; $display("FAIL signs_dz[%0d] got %b exp 0", i, bus.div_zero); end
        end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        launch(32'd7, 32'd2);
        wait_done(lat, bc);
        launch(32'd100, 32'd0);
        wait_done(lat, bc);
        tests++; if (lat != 1) begin fails++; $display("FAIL zero_latency got %0d exp 1", lat); end
        tests++; if (bc != 1) begin fails++; $display("FAIL zero_busy_cycles got %0d exp 1", bc); end
        tests++; if (bus.div_zero !== 1'b1) begin fails++; $display("FAIL zero_dz got %b exp 1", bus.div_zero); end
        tests++; if (bus.hi !== 32'd1) begin fails++; $display("FAIL zero_hi_held got %h exp 1", bus.hi); end
        tests++; if (bus.lo !== 32'd3) begin fails++; $display("FAIL zero_lo_held got %h exp 3", bus.lo); end
        @(posedge clock);
        #1;
        tests++; if (bus.div_zero !== 1'b1) begin fails++; $display("FAIL zero_dz_hold got %b exp 1", bus.div_zero); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL zero_done_width got %b exp 0", bus.done); end
        launch(32'd9, 32'd3);
        wait_done(lat, bc);
        tests++; if (bus.div_zero !== 1'b0) begin fails++; $display("FAIL zero_dz_clear got %b exp 0", bus.div_zero); end
        tests++; if (bus.lo !== 32'd3) begin fails++; $display("FAIL zero_next_lo got %h exp 3", bus.lo); end
        tests++; if (bus.hi !== 32'd0) begin fails++; $display("FAIL zero_next_hi got %h exp 0", bus.hi); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        launch(32'd20, 32'd6);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        // Start while busy must be dropped, not queued.
        bus.a     = 32'd50;
        bus.b     = 32'd5;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        wait_done(lat, bc);
        tests++; if (lat != 23) begin fails++; $display("FAIL b2b_first_latency got %0d exp 23", lat); end
        tests++; if (bus.lo !== 32'd3) begin fails++; $display("FAIL b2b_first_lo got %h exp 3", bus.lo); end
        tests++; if (bus.hi !== 32'd2) begin fails++; $display("FAIL b2b_first_hi got %h exp 2", bus.hi); end
        launch(32'd50, 32'd5);
        wait_done(lat, bc);
        tests++; if (lat != 33) begin fails++; $display("FAIL b2b_second_latency got %0d exp 33", lat); end
        tests++; if (bus.lo !== 32'd10) begin fails++; $display("FAIL b2b_second_lo got %h exp 10", bus.lo); end
        tests++; if (bus.hi !== 32'd0) begin fails++; $display("FAIL b2b_second_hi got %h exp 0", bus.hi); end
    endtask

    task automatic test_reset_abort();
        int lat, bc;
        int extra_done;
        launch(32'd1000, 32'd7);
        repeat (14) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        exp_dz = 1'b0;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL abort_done got %b exp 0", bus.done); end
        tests++; if (bus.lo !== '0) begin fails++; $display("FAIL abort_lo got %h exp 0", bus.lo); end
        tests++; if (bus.hi !== '0) begin fails++; $display("FAIL abort_hi got %h exp 0", bus.hi); end
        @(negedge clock);
        reset = 1'b1;
        extra_done = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done) extra_done++;
        end
        tests++; if (extra_done != 0) begin fails++; $display("FAIL abort_stray_done got %0d exp 0", extra_done); end
        launch(32'd1000, 32'd7);
        wait_done(lat, bc);
        tests++; if (bus.lo !== 32'd142) begin fails++; $display("FAIL abort_fresh_lo got %h exp 142", bus.lo); end
        tests++; if (bus.hi !== 32'd6) begin fails++; $display("FAIL abort_fresh_hi got %h exp 6", bus.hi); end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        int lat, bc, exp_lat;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = '0;
                1: b = 32'hFFFF_FFFF;
                2: begin
                    b = $urandom_range(1, 15);
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                3: a = 32'h8000_0000;
                default: ;
            endcase
            launch(a, b);
            exp_lat = (b == '0) ? 1 : 33;
            wait_done(lat, bc);
            tests++; if (bus.lo !== exp_lo) begin fails++; $display("FAIL rand_lo a=%h b=%h got %h exp %h", a, b, bus.lo, exp_lo); end
            tests++; if (bus.hi !== exp_hi) begin fails++; $display("FAIL rand_hi a=%h b=%h got %h exp %h", a, b, bus.hi, exp_hi); end
            tests++; if (bus.div_zero !== exp_dz) begin fails++; $display("FAIL rand_dz a=%h b=%h got %b exp %b", a, b, bus.div_zero, exp_dz); end
            tests++; if (lat != exp_lat) begin fails++; $display("FAIL rand_latency a=%h b=%h got %0d exp %0d", a, b, lat, exp_lat); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
